// File: rtl/fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_ctrl_if
//  Purpose  : Write-side bundle of the async FIFO: producer request, read
//             pointer synchronized into the write domain, RAM write port,
//             Gray write pointer, full and overflow status.
//             Level outputs exist only when FIFO_WLEVEL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 wr_en_i;
    logic [ADDR_SIZE:0]   rptr_sync_i;
    logic                 ovf_clr_i;
    logic [ADDR_SIZE-1:0] waddr_o;
    logic                 wr_o;
    logic [ADDR_SIZE:0]   wptr_o;
    logic                 wfull_o;
    logic                 overflow_o;
`ifdef FIFO_WLEVEL_EN
    logic [ADDR_SIZE:0]   wlevel_o;
    logic                 wafull_o;
`endif

    // Producer / environment side
    modport master (
        output wr_en_i, rptr_sync_i, ovf_clr_i,
`ifdef FIFO_WLEVEL_EN
        input  wlevel_o, wafull_o,
`endif
        input  waddr_o, wr_o, wptr_o, wfull_o, overflow_o
    );

    // Write controller side
    modport slave (
        input  wr_en_i, rptr_sync_i, ovf_clr_i,
`ifdef FIFO_WLEVEL_EN
        output wlevel_o, wafull_o,
`endif
        output waddr_o, wr_o, wptr_o, wfull_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_ctrl
//  Purpose  : Write-side controller of the async FIFO. Owns the binary and
//             Gray write pointers, RAM write address/strobe, the registered
//             full flag and a sticky overflow flag. Consumes the read pointer
//             already synchronized into this clock domain.
//  Options  : FIFO_WLEVEL_EN - adds registered fill level and almost-full.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_ctrl #(
    parameter int ADDR_SIZE   = 8
`ifdef FIFO_WLEVEL_EN
   ,parameter int AFULL_LEVEL = 2**ADDR_SIZE - 4
`endif
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    fifo_wr_ctrl_if.slave   bus
);

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] wbin_next;
    logic [ADDR_SIZE:0] wgray_next;
    logic [ADDR_SIZE:0] full_pattern;
    logic               accept;
    logic               reject;
    logic               full_next;
    logic [ADDR_SIZE:0] wptr;
    logic               wfull;
    logic               overflow;

    assign accept = bus.wr_en_i & ~wfull;
    assign reject = bus.wr_en_i &  wfull;

    // Next pointer includes this cycle's accepted write so that full is
    // raised on the same edge the pointer reaches the full position.
    assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, accept};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted, remaining bits equal.
    assign full_pattern = {~bus.rptr_sync_i[ADDR_SIZE:ADDR_SIZE-1],
                            bus.rptr_sync_i[ADDR_SIZE-2:0]};
    assign full_next    = (wgray_next == full_pattern);

    // Pointer and full flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wbin  <= '0;
            wptr  <= '0;
            wfull <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wptr  <= wgray_next;
            wfull <= full_next;
        end
    end

    // Sticky overflow: a rejected write wins over a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (reject) begin
            overflow <= 1'b1;
        end else if (bus.ovf_clr_i) begin
            overflow <= 1'b0;
        end
    end

    assign bus.waddr_o    = wbin[ADDR_SIZE-1:0];
    assign bus.wr_o       = accept;
    assign bus.wptr_o     = wptr;
    assign bus.wfull_o    = wfull;
    assign bus.overflow_o = overflow;

`ifdef FIFO_WLEVEL_EN
    localparam logic [ADDR_SIZE:0] AFULL_THR = AFULL_LEVEL[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] level_next;
    logic [ADDR_SIZE:0] wlevel;
    logic               wafull;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rbin[i] = ^(bus.rptr_sync_i >> i);
        end
    end

    // Modulo subtraction gives the correct occupancy across wrap
    assign level_next = wbin_next - rbin;

    // Level registers, updated on the same edge as the write pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wlevel <= '0;
            wafull <= 1'b0;
        end else begin
            wlevel <= level_next;
            wafull <= (level_next >= AFULL_THR);
        end
    end

    assign bus.wlevel_o = wlevel;
    assign bus.wafull_o = wafull;
`endif

endmodule
`default_nettype wire
